sa_inst_sequencer: RTL and testbench
====================================

Name: sa_inst_sequencer

Overview:
- Loop-descriptor instruction sequencer that drives the systolic array instruction port (init_inst_pulse / instruction / idle_flag / flag).
- Accepts one descriptor: opcode, two base addresses, two signed strides, repeat count.
- Issues `count` instructions, one at a time, each using the array's pulse/idle/flag handshake.
- Replaces software-issued instruction loops (data/weight loads, MAT_MUL sweeps, ACC_TO_UB, UB_TO_AXI).

Parameters:
- OPCODE_BITS, 8, opcode field width.
- ADDR_BITS, 16, width of each address field (ADDRA and ADDRB) and of each stride.
- CNT_BITS, 9, repeat-count width (maximum 511 instructions).
- TIMEOUT_CYCLES, 65535, watchdog limit per instruction; used only with SA_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  sequencer can accept a descriptor.
- cmd_opcode  in  OPCODE_BITS  opcode issued on every iteration.
- cmd_addra_base  in  ADDR_BITS  ADDRA for iteration 0.
- cmd_addrb_base  in  ADDR_BITS  ADDRB for iteration 0.
- cmd_addra_stride  in  ADDR_BITS  signed ADDRA increment per iteration.
- cmd_addrb_stride  in  ADDR_BITS  signed ADDRB increment per iteration.
- cmd_count  in  CNT_BITS  number of instructions to issue.
- init_inst_pulse  out  1  instruction request to the array.
- instruction  out  OPCODE_BITS+2*ADDR_BITS  {opcode, addra, addrb}, MSB first.
- idle_flag  in  1  array idle; falls when the array accepts an instruction.
- flag  in  1  array instruction-complete level.
- busy  out  1  descriptor in progress.
- done_pulse  out  1  one-cycle pulse when the descriptor finishes.
- iter_idx  out  CNT_BITS  index of the instruction currently issued.
- timeout_err  out  1  sticky watchdog error; exists only with SA_SEQ_TIMEOUT_EN.

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - State IDLE; internal address and count registers 0.
  - Reset is asynchronous and may assert mid-descriptor: the sequencer abandons the descriptor and drives init_inst_pulse low immediately.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch all cmd_* fields and clear iter_idx and the address registers to the bases.
  - count == 0: go to FINISH (no instruction issued).
  - Otherwise go to ISSUE.
- ISSUE:
  - Waits for idle_flag == 1.
  - Drives instruction from the registers and raises init_inst_pulse, registered, in the cycle after idle_flag is seen high.
  - Then goes to WAIT_ACK.
- WAIT_ACK:
  - Holds init_inst_pulse and instruction stable until idle_flag is sampled 0.
  - Then drops init_inst_pulse the next cycle and goes to WAIT_DONE.
- WAIT_DONE:
  - Waits for flag == 1 (level). The array clears flag when it leaves idle, so a stale flag cannot be seen here.
  - On flag:
    - If iter_idx == count-1, go to FINISH.
    - Otherwise iter_idx++, addra += stride_a, addrb += stride_b, and go to ISSUE.
- FINISH: done_pulse = 1 for one cycle, busy = 0, return to IDLE.
- cmd_ready is 0 in every state except IDLE. A descriptor presented while busy is held off, never dropped.
- busy = 1 from the cycle after acceptance through the cycle before FINISH.
- Address arithmetic:
  - Modulo 2^ADDR_BITS; strides are two's complement.
  - Wrap-around is silent (for example, 0xFFF0 + 0x0010 = 0x0000).
- Latency:
  - Acceptance to first init_inst_pulse high: 2 cycles when idle_flag is already high.
  - flag high to next init_inst_pulse high: 2 cycles.
- If idle_flag and flag are both seen in the same WAIT_ACK cycle, only the ack is taken; flag is evaluated in WAIT_DONE.

Optional Feature:
- Macro: SA_SEQ_TIMEOUT_EN.
- Enabled:
  - A per-instruction cycle counter runs in WAIT_ACK and WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES, the sequencer drops init_inst_pulse, sets timeout_err (sticky until reset), emits done_pulse, and returns to IDLE.
- Disabled: no counter, no timeout_err port; the sequencer waits indefinitely.

Decomposition:
- Shared package holds OPCODE_BITS, the address widths, the instruction field positions (OPCODE_FROM/TO, ADDRA_FROM/TO, ADDRB_FROM/TO), the opcode constants (AXI_TO_UB_INST, MAT_MUL_INST, ...), and the FSM state encoding.
- One natural sub-module: sa_seq_addr_gen, holding the base/stride address registers and the iteration counter, with a load/step interface.

Test Plan:
- AXI_TO_UB, count 4, both bases 0, strides 16, with an array model: 4 instructions, addra = addrb = 0, 16, 32, 48; one done_pulse after the 4th flag.
- AXI_TO_WB, count 3, addra base 0 stride 16, addrb base 0x0FF0 stride -16: addrb = 0x0FF0, 0x0FE0, 0x0FD0.
- count 0: no init_inst_pulse; done_pulse 2 cycles after acceptance; cmd_ready back to 1.
- Wrap: addra base 0xFFF0, stride 16, count 2: addra = 0xFFF0, then 0x0000.
- cmd_valid held while busy: cmd_ready stays 0; the second descriptor is accepted in the IDLE cycle after done_pulse and its instructions follow.
- reset_n low while in WAIT_DONE: outputs clear asynchronously, cmd_ready = 1. With SA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 20, an array model that never raises flag gives timeout_err = 1 and done_pulse on cycle 20.

Source files
------------

// File: rtl/sa_inst_sequencer_pkg.sv
// Shared widths, instruction field positions, opcode constants and FSM encoding
// for the systolic-array instruction sequencer.
package sa_inst_sequencer_pkg;

    localparam int OPCODE_BITS = 8;
    localparam int ADDR_BITS   = 16;
    localparam int CNT_BITS    = 9;
    localparam int INST_BITS   = OPCODE_BITS + 2 * ADDR_BITS;

    // instruction = {opcode, addra, addrb}, MSB first
    localparam int ADDRB_FROM  = 0;
    localparam int ADDRB_TO    = ADDR_BITS - 1;
    localparam int ADDRA_FROM  = ADDR_BITS;
    localparam int ADDRA_TO    = 2 * ADDR_BITS - 1;
    localparam int OPCODE_FROM = 2 * ADDR_BITS;
    localparam int OPCODE_TO   = INST_BITS - 1;

    localparam logic [OPCODE_BITS-1:0] NOP_INST       = 8'h00;
    localparam logic [OPCODE_BITS-1:0] AXI_TO_UB_INST = 8'h01;
    localparam logic [OPCODE_BITS-1:0] AXI_TO_WB_INST = 8'h02;
    localparam logic [OPCODE_BITS-1:0] MAT_MUL_INST   = 8'h03;
    localparam logic [OPCODE_BITS-1:0] ACC_TO_UB_INST = 8'h04;
    localparam logic [OPCODE_BITS-1:0] UB_TO_AXI_INST = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/sa_seq_addr_gen.sv
// Base/stride address generator and iteration counter for the instruction
// sequencer: load sets addresses to the bases, step advances one iteration.
module sa_seq_addr_gen #(
    parameter int ADDR_BITS = 16,
    parameter int CNT_BITS  = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [ADDR_BITS-1:0] base_a,
    input  logic [ADDR_BITS-1:0] base_b,
    input  logic [ADDR_BITS-1:0] stride_a,
    input  logic [ADDR_BITS-1:0] stride_b,
    output logic [ADDR_BITS-1:0] addra,
    output logic [ADDR_BITS-1:0] addrb,
    output logic [CNT_BITS-1:0]  idx
);

    logic [ADDR_BITS-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [ADDR_BITS-1:0] stride_a_q, stride_a_d, stride_b_q, stride_b_d;
    logic [CNT_BITS-1:0]  idx_q, idx_d;

    always_comb begin
        addra_d    = addra_q;
        addrb_d    = addrb_q;
        stride_a_d = stride_a_q;
        stride_b_d = stride_b_q;
        idx_d      = idx_q;
        if (load) begin
            addra_d    = base_a;
            addrb_d    = base_b;
            stride_a_d = stride_a;
            stride_b_d = stride_b;
            idx_d      = '0;
        end else if (step) begin
            // Unsigned add of a two's-complement stride wraps modulo 2^ADDR_BITS.
            addra_d = addra_q + stride_a_q;
            addrb_d = addrb_q + stride_b_q;
            idx_d   = idx_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addra_q    <= '0;
            addrb_q    <= '0;
            stride_a_q <= '0;
            stride_b_q <= '0;
            idx_q      <= '0;
        end else begin
            addra_q    <= addra_d;
            addrb_q    <= addrb_d;
            stride_a_q <= stride_a_d;
            stride_b_q <= stride_b_d;
            idx_q      <= idx_d;
        end
    end

    assign addra = addra_q;
    assign addrb = addrb_q;
    assign idx   = idx_q;

endmodule

// File: rtl/sa_inst_sequencer.sv
// Loop-descriptor sequencer issuing `count` instructions over the array's
// pulse/idle/flag handshake. Optional per-instruction watchdog: SA_SEQ_TIMEOUT_EN.
module sa_inst_sequencer #(
    parameter int OPCODE_BITS = sa_inst_sequencer_pkg::OPCODE_BITS,
    parameter int ADDR_BITS   = sa_inst_sequencer_pkg::ADDR_BITS,
    parameter int CNT_BITS    = sa_inst_sequencer_pkg::CNT_BITS
`ifdef SA_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [OPCODE_BITS-1:0]             cmd_opcode,
    input  logic [ADDR_BITS-1:0]               cmd_addra_base,
    input  logic [ADDR_BITS-1:0]               cmd_addrb_base,
    input  logic [ADDR_BITS-1:0]               cmd_addra_stride,
    input  logic [ADDR_BITS-1:0]               cmd_addrb_stride,
    input  logic [CNT_BITS-1:0]                cmd_count,
    output logic                               init_inst_pulse,
    output logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
    input  logic                               idle_flag,
    input  logic                               flag,
    output logic                               busy,
    output logic                               done_pulse,
    output logic [CNT_BITS-1:0]                iter_idx
`ifdef SA_SEQ_TIMEOUT_EN
    ,
    output logic                               timeout_err
`endif
);
    import sa_inst_sequencer_pkg::*;

    localparam int INST_W = OPCODE_BITS + 2 * ADDR_BITS;

    seq_state_e              state_q, state_d;
    logic [OPCODE_BITS-1:0]  opcode_q, opcode_d;
    logic [CNT_BITS-1:0]     count_q, count_d;
    logic [INST_W-1:0]       instr_q, instr_d;
    logic                    pulse_q, pulse_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic                    gen_load, gen_step;
    logic [ADDR_BITS-1:0]    addra, addrb;
    logic [CNT_BITS-1:0]     iter;

`ifdef SA_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    sa_seq_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .CNT_BITS  (CNT_BITS)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (gen_load),
        .step     (gen_step),
        .base_a   (cmd_addra_base),
        .base_b   (cmd_addrb_base),
        .stride_a (cmd_addra_stride),
        .stride_b (cmd_addrb_stride),
        .addra    (addra),
        .addrb    (addrb),
        .idx      (iter)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pulse_d  = pulse_q;
        done_d   = 1'b0;
        gen_load = 1'b0;
        gen_step = 1'b0;
`ifdef SA_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    opcode_d = cmd_opcode;
                    count_d  = cmd_count;
                    gen_load = 1'b1;
                    state_d  = (cmd_count == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (idle_flag) begin
                    instr_d = {opcode_q, addra, addrb};
                    pulse_d = 1'b1;
                    state_d = ST_WAIT_ACK;
`ifdef SA_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            // flag is deliberately ignored here; it is only meaningful after the ack.
            ST_WAIT_ACK: begin
                if (!idle_flag) begin
                    pulse_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (flag) begin
                    if (iter == count_q - CNT_BITS'(1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        gen_step = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SA_SEQ_TIMEOUT_EN
        if (state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                pulse_d  = 1'b0;
                err_d    = 1'b1;
                done_d   = 1'b1;
                gen_step = 1'b0;
                state_d  = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK) || (state_d == ST_WAIT_DONE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef SA_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
`ifdef SA_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign cmd_ready       = ready_q;
    assign init_inst_pulse = pulse_q;
    assign instruction     = instr_q;
    assign busy            = busy_q;
    assign done_pulse      = done_q;
    assign iter_idx        = iter;
`ifdef SA_SEQ_TIMEOUT_EN
    assign timeout_err     = err_q;
`endif

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// Self-checking bench for sa_inst_sequencer: randomized array-side handshake
// model plus a closed-form reference for the expected instruction stream.
module tb_sa_inst_sequencer;
    import sa_inst_sequencer_pkg::*;

    localparam int OB = 8;
    localparam int AB = 16;
    localparam int CB = 9;
    localparam int IB = OB + 2 * AB;
`ifdef SA_SEQ_TIMEOUT_EN
    localparam int TMO = 20;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [OB-1:0] cmd_opcode = '0;
    logic [AB-1:0] cmd_addra_base = '0, cmd_addrb_base = '0;
    logic [AB-1:0] cmd_addra_stride = '0, cmd_addrb_stride = '0;
    logic [CB-1:0] cmd_count = '0;
    logic          init_inst_pulse;
    logic [IB-1:0] instruction;
    logic          idle_flag = 1'b1;
    logic          flag = 1'b0;
    logic          busy, done_pulse;
    logic [CB-1:0] iter_idx;
`ifdef SA_SEQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    always #5 clk = ~clk;

    sa_inst_sequencer #(
        .OPCODE_BITS (OB),
        .ADDR_BITS   (AB),
        .CNT_BITS    (CB)
`ifdef SA_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_opcode       (cmd_opcode),
        .cmd_addra_base   (cmd_addra_base),
        .cmd_addrb_base   (cmd_addrb_base),
        .cmd_addra_stride (cmd_addra_stride),
        .cmd_addrb_stride (cmd_addrb_stride),
        .cmd_count        (cmd_count),
        .init_inst_pulse  (init_inst_pulse),
        .instruction      (instruction),
        .idle_flag        (idle_flag),
        .flag             (flag),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .iter_idx         (iter_idx)
`ifdef SA_SEQ_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor / array model state
    int            cyc = 0;
    logic [IB-1:0] got_q[$];
    int            pulse_rises = 0, done_cnt = 0, last_done_cyc = 0;
    int            accept_cyc = 0, first_pulse_cyc = 0, last_flag_cyc = 0;
    int            lat_bad = 0, stab_bad = 0;
    int            hang_after = 1000000;
    bit            seen_first = 1'b0, a_busy = 1'b0, prev_pulse = 1'b0;
    logic [IB-1:0] prev_instr = '0;
    int            ack_dly = 0, done_dly = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            a_busy     = 1'b0;
            idle_flag  = 1'b1;
            flag       = 1'b0;
            prev_pulse = 1'b0;
        end else begin
            if (init_inst_pulse && !prev_pulse) begin
                pulse_rises++;
                if (!seen_first) begin
                    first_pulse_cyc = cyc;
                    seen_first      = 1'b1;
                end else if (cyc - last_flag_cyc != 2) begin
                    lat_bad++;
                end
            end
            if (init_inst_pulse && prev_pulse && instruction !== prev_instr) stab_bad++;
            if (done_pulse) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                accept_cyc = cyc;
                seen_first = 1'b0;
            end
            prev_pulse = init_inst_pulse;
            prev_instr = instruction;
            // Array side: accept after a random hold, complete after a random latency.
            if (!a_busy) begin
                if (init_inst_pulse && idle_flag) begin
                    if (ack_dly == 0) begin
                        got_q.push_back(instruction);
                        idle_flag = 1'b0;
                        flag      = 1'b0;
                        a_busy    = 1'b1;
                        done_dly  = $urandom_range(0, 4);
                        ack_dly   = $urandom_range(0, 2);
                    end else begin
                        ack_dly--;
                    end
                end
            end else if (got_q.size() <= hang_after) begin
                if (done_dly == 0) begin
                    flag          = 1'b1;
                    idle_flag     = 1'b1;
                    a_busy        = 1'b0;
                    last_flag_cyc = cyc;
                end else begin
                    done_dly--;
                end
            end
        end
    end

    // Reference: iteration i uses base + i*stride, modulo 2^AB.
    function automatic logic [IB-1:0] ref_inst(input logic [OB-1:0] op, input logic [AB-1:0] ba,
                                               input logic [AB-1:0] bb, input logic [AB-1:0] sa,
                                               input logic [AB-1:0] sb, input int i);
        logic [AB-1:0] a, b;
        a = ba + AB'(i) * sa;
        b = bb + AB'(i) * sb;
        return {op, a, b};
    endfunction

    task automatic send(input logic [OB-1:0] op, input logic [AB-1:0] ba, input logic [AB-1:0] bb,
                        input logic [AB-1:0] sa, input logic [AB-1:0] sb, input int cnt, output bit ok);
        cmd_opcode       = op;
        cmd_addra_base   = ba;
        cmd_addrb_base   = bb;
        cmd_addra_stride = sa;
        cmd_addrb_stride = sb;
        cmd_count        = CB'(cnt);
        cmd_valid        = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                @(posedge clk); #2;
                break;
            end
            @(posedge clk); #2;
        end
        cmd_valid = 1'b0;
        $display("desc op=%02h a=%04h/%04h b=%04h/%04h cnt=%0d accepted=%0b", op, ba, sa, bb, sb, cnt, ok);
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done_cnt >= target) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        n_cmp++; if (init_inst_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got=%b exp=0", init_inst_pulse); end
        n_cmp++; if (busy !== 1'b0 || done_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done_pulse); end
        n_cmp++; if (instruction !== '0 || iter_idx !== '0) begin n_bad++; $display("FAIL reset_inst_idx got=%h/%0d exp=0/0", instruction, iter_idx); end
    endtask

    task automatic test_axi_to_ub;
        bit ok, okd; int d0;
        got_q.delete(); lat_bad = 0; stab_bad = 0; d0 = done_cnt;
        send(AXI_TO_UB_INST, 16'h0000, 16'h0000, 16'd16, 16'd16, 4, ok);
        wait_done(d0 + 1, okd);
        repeat (3) begin @(posedge clk); #2; end
        n_cmp++; if (!ok || !okd) begin n_bad++; $display("FAIL ub_handshake got=%b%b exp=11", ok, okd); end
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL ub_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== ref_inst(AXI_TO_UB_INST, 16'h0, 16'h0, 16'd16, 16'd16, i)) begin
                n_bad++; $display("FAIL ub_inst[%0d] got=%h exp=%h", i, got_q[i], ref_inst(AXI_TO_UB_INST, 16'h0, 16'h0, 16'd16, 16'd16, i));
            end
        end
        n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL ub_done_count got=%0d exp=%0d", done_cnt - d0, 1); end
        n_cmp++; if (first_pulse_cyc - accept_cyc != 2) begin n_bad++; $display("FAIL ub_first_latency got=%0d exp=2", first_pulse_cyc - accept_cyc); end
        n_cmp++; if (lat_bad != 0 || stab_bad != 0) begin n_bad++; $display("FAIL ub_flag_latency_stability got=%0d/%0d exp=0/0", lat_bad, stab_bad); end
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL ub_idle_after got=%b%b exp=10", cmd_ready, busy); end
    endtask

    task automatic test_axi_to_wb;
        bit ok, okd; int d0;
        got_q.delete(); d0 = done_cnt;
        send(AXI_TO_WB_INST, 16'h0000, 16'h0FF0, 16'd16, 16'hFFF0, 3, ok);
        wait_done(d0 + 1, okd);
        n_cmp++; if (!ok || !okd || got_q.size() != 3) begin n_bad++; $display("FAIL wb_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== ref_inst(AXI_TO_WB_INST, 16'h0, 16'h0FF0, 16'd16, 16'hFFF0, i)) begin
                n_bad++; $display("FAIL wb_inst[%0d] got=%h exp=%h", i, got_q[i], ref_inst(AXI_TO_WB_INST, 16'h0, 16'h0FF0, 16'd16, 16'hFFF0, i));
            end
        end
    endtask

    task automatic test_count_zero;
        bit ok, okd; int d0, p0;
        d0 = done_cnt; p0 = pulse_rises;
        send(MAT_MUL_INST, 16'h1234, 16'h5678, 16'd1, 16'd1, 0, ok);
        wait_done(d0 + 1, okd);
        n_cmp++; if (!ok || !okd) begin n_bad++; $display("FAIL zero_done got=%b%b exp=11", ok, okd); end
        n_cmp++; if (pulse_rises != p0) begin n_bad++; $display("FAIL zero_pulses got=%0d exp=0", pulse_rises - p0); end
        n_cmp++; if (last_done_cyc - accept_cyc != 2) begin n_bad++; $display("FAIL zero_latency got=%0d exp=2", last_done_cyc - accept_cyc); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_wrap;
        bit ok, okd; int d0;
        got_q.delete(); d0 = done_cnt;
        send(ACC_TO_UB_INST, 16'hFFF0, 16'h0008, 16'h0010, 16'hFFFF, 2, ok);
        wait_done(d0 + 1, okd);
        n_cmp++; if (!ok || !okd || got_q.size() != 2) begin n_bad++; $display("FAIL wrap_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++;
            if (got_q[1][ADDRA_TO:ADDRA_FROM] !== 16'h0000 || got_q[0][ADDRA_TO:ADDRA_FROM] !== 16'hFFF0) begin
                n_bad++; $display("FAIL wrap_addra got=%h,%h exp=fff0,0000", got_q[0][ADDRA_TO:ADDRA_FROM], got_q[1][ADDRA_TO:ADDRA_FROM]);
            end
            n_cmp++;
            if (got_q[1] !== ref_inst(ACC_TO_UB_INST, 16'hFFF0, 16'h0008, 16'h0010, 16'hFFFF, 1)) begin
                n_bad++; $display("FAIL wrap_inst1 got=%h exp=%h", got_q[1], ref_inst(ACC_TO_UB_INST, 16'hFFF0, 16'h0008, 16'h0010, 16'hFFFF, 1));
            end
        end
    endtask

    task automatic test_random;
        bit ok, okd; int d0, cnt, bad;
        logic [OB-1:0] op; logic [AB-1:0] ba, bb, sa, sb;
        for (int t = 0; t < 6; t++) begin
            got_q.delete(); lat_bad = 0; stab_bad = 0; d0 = done_cnt; bad = 0;
            op = OB'($urandom_range(1, 5)); ba = AB'($urandom); bb = AB'($urandom);
            sa = AB'($urandom); sb = AB'($urandom); cnt = $urandom_range(1, 7);
            send(op, ba, bb, sa, sb, cnt, ok);
            wait_done(d0 + 1, okd);
            for (int i = 0; i < cnt && i < got_q.size(); i++)
                if (got_q[i] !== ref_inst(op, ba, bb, sa, sb, i)) bad++;
            n_cmp++;
            if (!ok || !okd || got_q.size() != cnt || bad != 0 || lat_bad != 0 || stab_bad != 0) begin
                n_bad++; $display("FAIL rand[%0d] got n=%0d bad=%0d lat=%0d stab=%0d exp n=%0d bad=0 lat=0 stab=0", t, got_q.size(), bad, lat_bad, stab_bad, cnt);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit ok, okd, early; int d0, first_done, bad;
        got_q.delete(); d0 = done_cnt; early = 1'b0; bad = 0;
        send(UB_TO_AXI_INST, 16'h0100, 16'h0200, 16'd4, 16'd8, 3, ok);
        cmd_opcode = MAT_MUL_INST; cmd_addra_base = 16'h0A00; cmd_addrb_base = 16'h0B00;
        cmd_addra_stride = 16'd1; cmd_addrb_stride = 16'hFFFE; cmd_count = CB'(2);
        cmd_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (cmd_ready) begin
                if (!done_pulse && done_cnt == d0) early = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        first_done = last_done_cyc;
        $display("desc op=%02h held while busy, accepted at cycle %0d", MAT_MUL_INST, accept_cyc);
        n_cmp++; if (!ok || early || done_cnt != d0 + 1) begin n_bad++; $display("FAIL b2b_holdoff got early=%b dones=%0d exp early=0 dones=1", early, done_cnt - d0); end
        n_cmp++; if (accept_cyc - first_done < 0 || accept_cyc - first_done > 1) begin n_bad++; $display("FAIL b2b_accept_cycle got=%0d exp=0..1", accept_cyc - first_done); end
        wait_done(d0 + 2, okd);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            if (got_q[i] !== ref_inst(UB_TO_AXI_INST, 16'h0100, 16'h0200, 16'd4, 16'd8, i)) bad++;
        for (int i = 0; i < 2 && i + 3 < got_q.size(); i++)
            if (got_q[i+3] !== ref_inst(MAT_MUL_INST, 16'h0A00, 16'h0B00, 16'd1, 16'hFFFE, i)) bad++;
        n_cmp++; if (!okd || got_q.size() != 5 || bad != 0) begin n_bad++; $display("FAIL b2b_stream got n=%0d bad=%0d exp n=5 bad=0", got_q.size(), bad); end
    endtask

    task automatic test_reset_mid;
        bit ok, reached;
        got_q.delete(); hang_after = 1; reached = 1'b0;
        send(MAT_MUL_INST, 16'h0100, 16'h0200, 16'd1, 16'd2, 3, ok);
        for (int i = 0; i < 500; i++) begin
            if (got_q.size() >= 2 && busy && !init_inst_pulse) begin reached = 1'b1; break; end
            @(posedge clk); #2;
        end
        n_cmp++; if (!reached || iter_idx !== CB'(1)) begin n_bad++; $display("FAIL rst_mid_reach got=%b idx=%0d exp=1 idx=1", reached, iter_idx); end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || init_inst_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ctrl got=%b%b%b exp=100", cmd_ready, busy, init_inst_pulse); end
        n_cmp++; if (instruction !== '0 || iter_idx !== '0 || done_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_mid_regs got=%h/%0d/%b exp=0/0/0", instruction, iter_idx, done_pulse); end
        @(posedge clk); #2;
        hang_after = 1000000;
        reset_n = 1'b1;
        @(posedge clk); #2;
    endtask

`ifdef SA_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        bit ok, okd; int d0;
        got_q.delete(); hang_after = 0; d0 = done_cnt;
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_initial got=%b exp=0", timeout_err); end
        send(AXI_TO_UB_INST, 16'h0, 16'h0, 16'd1, 16'd1, 2, ok);
        wait_done(d0 + 1, okd);
        n_cmp++; if (!okd || timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        n_cmp++; if (last_done_cyc - first_pulse_cyc != TMO) begin n_bad++; $display("FAIL tmo_cycle got=%0d exp=%0d", last_done_cyc - first_pulse_cyc, TMO); end
        n_cmp++; if (cmd_ready !== 1'b1 || init_inst_pulse !== 1'b0) begin n_bad++; $display("FAIL tmo_idle got=%b%b exp=10", cmd_ready, init_inst_pulse); end
        #1 reset_n = 1'b0;
        @(posedge clk); #2;
        hang_after = 1000000;
        reset_n = 1'b1;
        @(posedge clk); #2;
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        #2;
        test_reset;
        reset_n = 1'b1;
        @(posedge clk); #2;
        test_reset;
        test_axi_to_ub;
        test_axi_to_wb;
        test_count_zero;
        test_wrap;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_axi_to_ub;
`ifdef SA_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
